// File: rtl/fft_frame_feeder.sv
// Show-ahead sample buffer that frames a free-running ADC stream into FFT-sized
// Avalon-ST packets (sop/eop) for a streaming FFT sink.
//
// state  | meaning
// IDLE   | waiting for enable with a legal frame length
// RUN    | accepting samples, frames repeat while enable is high
// FINISH | enable dropped mid-frame; accepting until the input frame completes
// DRAIN  | no more input; emptying buffer until the last eop is accepted
module fft_frame_feeder #(
  parameter int DEPTH = 64,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [14:0]   fftpts_cfg,
  input  logic          inverse_cfg,
  input  logic          in_valid,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  input  logic          out_ready,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic [1:0]    out_error,
  output logic [14:0]   out_fftpts,
  output logic          out_inverse,
  output logic          busy,
  output logic          overflow,
  input  logic          clear_overflow,
  output logic          cfg_error,
  output logic [15:0]   frames_done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]    state;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem_real [DEPTH];
  logic [DW-1:0] mem_imag [DEPTH];
  logic [14:0]   in_cnt;
  logic [14:0]   in_cnt_next;
  logic [14:0]   out_cnt;
  logic [14:0]   fftpts_q;
  logic          inverse_q;
  logic          overflow_q;
  logic          cfg_error_q;
  logic [15:0]   frames_q;
  logic          empty;
  logic          full;
  logic          accepting;
  logic          rd_en;
  logic          wr_en;
  logic          drop;
  logic          in_last;
  logic          out_last;
  logic          cfg_legal;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign accepting = (state == S_RUN) || (state == S_FINISH);
  assign rd_en     = !empty && out_ready;
  assign wr_en     = accepting && in_valid && (!full || rd_en);
  assign drop      = accepting && in_valid && full && !rd_en;
  assign in_last   = (in_cnt == fftpts_q - 15'd1);
  assign out_last  = (out_cnt == fftpts_q - 15'd1);

  assign cfg_legal = (fftpts_cfg >= 15'd8) && (fftpts_cfg <= 15'd16384) &&
                     ((fftpts_cfg & (fftpts_cfg - 15'd1)) == 15'd0);

  always_comb begin
    in_cnt_next = in_cnt;
    if (wr_en) in_cnt_next = in_last ? 15'd0 : in_cnt + 15'd1;
  end

  // A write landing on the same edge that enable is seen low still counts
  // toward the current frame, so the stop decision looks at the updated count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      fftpts_q    <= '0;
      inverse_q   <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            if (cfg_legal) begin
              state       <= S_RUN;
              fftpts_q    <= fftpts_cfg;
              inverse_q   <= inverse_cfg;
              cfg_error_q <= 1'b0;
            end else begin
              cfg_error_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!enable) state <= (in_cnt_next != 15'd0) ? S_FINISH : S_DRAIN;
        end
        S_FINISH: begin
          if (wr_en && in_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (empty && (out_cnt == 15'd0)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      frames_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      in_cnt <= in_cnt_next;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_cnt <= out_last ? 15'd0 : out_cnt + 15'd1;
        if (out_last) frames_q <= frames_q + 16'd1;
      end
      if (drop) overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_real[wr_ptr[AW-1:0]] <= in_real;
      mem_imag[wr_ptr[AW-1:0]] <= in_imag;
    end
  end

  assign out_valid   = !empty;
  assign out_real    = empty ? '0 : mem_real[rd_ptr[AW-1:0]];
  assign out_imag    = empty ? '0 : mem_imag[rd_ptr[AW-1:0]];
  assign out_sop     = !empty && (out_cnt == 15'd0);
  assign out_eop     = !empty && out_last;
  assign out_error   = 2'b00;
  assign out_fftpts  = fftpts_q;
  assign out_inverse = inverse_q;
  assign busy        = (state != S_IDLE);
  assign overflow    = overflow_q;
  assign cfg_error   = cfg_error_q;
  assign frames_done = frames_q;

endmodule
